// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage sequencer: owns PCF, IF/ID and a 1-entry skid
// Drives a variable-latency req/ack instruction memory; redirects kill in-flight words.
module fetch_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_d,
    input  logic                  redirect_e,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pc_plus4_d,
    output logic                  fetch_busy
);

    typedef enum logic [1:0] {BOOT, FETCH, DROP, HOLD} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   pcf;
    logic [DATA_WIDTH-1:0]   drop_addr;
    logic [DATA_WIDTH-1:0]   skid_instr;
    logic [DATA_WIDTH-1:0]   skid_pc;
    logic                    skid_valid;

    logic                    fresh;
    logic [DATA_WIDTH-1:0]   pcf_inc;
    logic [DATA_WIDTH-1:0]   redirect_tgt;

    assign fresh        = (state == FETCH) && imem_ack && !redirect_e;
    assign pcf_inc      = pcf + DATA_WIDTH'(4);
    assign redirect_tgt = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

    // While dropping, the memory must keep seeing the killed request's address.
    assign imem_req   = (state == FETCH) || (state == DROP);
    assign imem_addr  = (state == DROP) ? drop_addr : pcf;
    assign fetch_busy = imem_req && !imem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BOOT;
            pcf        <= RESET_PC;
            drop_addr  <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
            if_valid   <= 1'b0;
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
        end else if (redirect_e) begin
            pcf        <= redirect_tgt;
            skid_valid <= 1'b0;
            if_valid   <= 1'b0;
            instr_d    <= NOP_INSTR;
            case (state)
                FETCH: begin
                    if (!imem_ack) begin
                        state     <= DROP;
                        drop_addr <= pcf;
                    end else begin
                        state <= FETCH;
                    end
                end
                // A same-cycle ack completes the killed request, so nothing is left to drop.
                DROP:    state <= imem_ack ? FETCH : DROP;
                default: state <= FETCH;
            endcase
        end else begin
            if (fresh) begin
                pcf <= pcf_inc;
            end
            if (!stall_d) begin
                if (skid_valid) begin
                    if_valid   <= 1'b1;
                    instr_d    <= skid_instr;
                    pc_d       <= skid_pc;
                    pc_plus4_d <= skid_pc + DATA_WIDTH'(4);
                    skid_valid <= 1'b0;
                end else if (fresh) begin
                    if_valid   <= 1'b1;
                    instr_d    <= imem_rdata;
                    pc_d       <= pcf;
                    pc_plus4_d <= pcf_inc;
                end else begin
                    if_valid <= 1'b0;
                    instr_d  <= NOP_INSTR;
                end
            end else if (fresh) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pcf;
                skid_valid <= 1'b1;
            end
            case (state)
                BOOT:  state <= FETCH;
                FETCH: if (fresh && stall_d) state <= HOLD;
                DROP:  if (imem_ack) state <= FETCH;
                HOLD:  if (!stall_d) state <= FETCH;
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_d;
    logic        redirect_e;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        fetch_busy;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall_d(stall_d), .redirect_e(redirect_e),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Reset and release at a negedge; returns in BOOT, one edge before the first request.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; stall_d = 1'b0; redirect_e = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; stall_d = 1'b0; redirect_e = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        #1;
        n_checks++;
        if ({imem_req, fetch_busy, if_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000", {imem_req, fetch_busy, if_valid});
        end
        n_checks++;
        if ({instr_d, pc_d, pc_plus4_d} !== {32'h13, 32'h0, 32'h0}) begin
            n_fail++; $display("FAIL reset_ifid: got %h %h %h want 13 0 0", instr_d, pc_d, pc_plus4_d);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL boot_req: got %b want 0", imem_req);
        end
        step();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL first_req: got %b %h want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        step();
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_fail++; $display("FAIL zw_valid_early: got %b want 0", if_valid);
        end
        for (int k = 0; k < 5; k++) begin
            imem_ack = imem_req; imem_rdata = imem_addr;
            #1;
            n_checks++;
            if ({imem_addr, fetch_busy} !== {32'(4 * k), 1'b0}) begin
                n_fail++; $display("FAIL zw_addr[%0d]: got %h busy %b want %h busy 0", k, imem_addr, fetch_busy, 4 * k);
            end
            step();
            n_checks++;
            if ({if_valid, pc_d, instr_d, pc_plus4_d} !== {1'b1, 32'(4 * k), 32'(4 * k), 32'(4 * k + 4)}) begin
                n_fail++; $display("FAIL zw_ifid[%0d]: got %b %h %h %h want 1 %h %h %h", k, if_valid, pc_d, instr_d, pc_plus4_d, 4 * k, 4 * k, 4 * k + 4);
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_delayed_ack();
        do_reset();
        step();
        imem_ack = 1'b1; imem_rdata = 32'hA0;
        step();
        for (int i = 0; i < 3; i++) begin
            imem_ack = (i == 2); imem_rdata = (i == 2) ? 32'h44 : 32'hDEAD;
            #1;
            n_checks++;
            if ({imem_req, imem_addr, fetch_busy} !== {1'b1, 32'h4, (i != 2)}) begin
                n_fail++; $display("FAIL dly_addr[%0d]: got %b %h busy %b want 1 00000004 busy %b", i, imem_req, imem_addr, fetch_busy, i != 2);
            end
            step();
            if (i < 2) begin
                n_checks++;
                if ({if_valid, instr_d} !== {1'b0, 32'h13}) begin
                    n_fail++; $display("FAIL dly_bubble[%0d]: got %b %h want 0 00000013", i, if_valid, instr_d);
                end
            end
        end
        n_checks++;
        if ({if_valid, pc_d, instr_d} !== {1'b1, 32'h4, 32'h44}) begin
            n_fail++; $display("FAIL dly_word: got %b %h %h want 1 00000004 00000044", if_valid, pc_d, instr_d);
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_redirect_drop();
        do_reset();
        step();
        imem_ack = 1'b1; imem_rdata = 32'h10;
        step();
        imem_rdata = 32'h14;
        step();
        imem_ack = 1'b0; redirect_e = 1'b1; redirect_pc = 32'h103;
        step();
        redirect_e = 1'b0;
        n_checks++;
        if ({imem_req, imem_addr, if_valid, fetch_busy} !== {1'b1, 32'h8, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL drop_hold_addr: got %b %h %b %b want 1 00000008 0 1", imem_req, imem_addr, if_valid, fetch_busy);
        end
        step();
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0008;
        step();
        n_checks++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h100, 1'b0}) begin
            n_fail++; $display("FAIL drop_new_addr: got %b %h %b want 1 00000100 0", imem_req, imem_addr, if_valid);
        end
        imem_rdata = 32'h100;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if ({if_valid, pc_d, instr_d, pc_plus4_d} !== {1'b1, 32'h100, 32'h100, 32'h104}) begin
            n_fail++; $display("FAIL drop_target_word: got %b %h %h %h want 1 100 100 104", if_valid, pc_d, instr_d, pc_plus4_d);
        end
    endtask

    task automatic test_stall_skid();
        do_reset();
        step();
        imem_ack = 1'b1; imem_rdata = 32'h50;
        step();
        stall_d = 1'b1; imem_rdata = 32'h54;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({imem_req, if_valid, pc_d, instr_d} !== {1'b0, 1'b1, 32'h0, 32'h50}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %b %b %h %h want 0 1 0 50", i, imem_req, if_valid, pc_d, instr_d);
            end
            if (i < 2) step();
        end
        step();
        stall_d = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL stall_release_req: got %b want 0", imem_req);
        end
        step();
        n_checks++;
        if ({if_valid, pc_d, instr_d, imem_req, imem_addr} !== {1'b1, 32'h4, 32'h54, 1'b1, 32'h8}) begin
            n_fail++; $display("FAIL skid_drain: got %b %h %h %b %h want 1 4 54 1 8", if_valid, pc_d, instr_d, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        step();
        imem_ack = 1'b1; imem_rdata = 32'h60;
        step();
        stall_d = 1'b1; imem_rdata = 32'h64;
        step();
        imem_ack = 1'b0; redirect_e = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_e = 1'b0; stall_d = 1'b0;
        n_checks++;
        if ({if_valid, instr_d, imem_req, imem_addr} !== {1'b0, 32'h13, 1'b1, 32'h200}) begin
            n_fail++; $display("FAIL hold_redirect: got %b %h %b %h want 0 13 1 200", if_valid, instr_d, imem_req, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'h200;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if ({if_valid, pc_d, instr_d} !== {1'b1, 32'h200, 32'h200}) begin
            n_fail++; $display("FAIL hold_target_word: got %b %h %h want 1 200 200", if_valid, pc_d, instr_d);
        end
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        redirect_e = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_e = 1'b0;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++; $display("FAIL wrap_addr: got %b %h want 1 fffffffc", imem_req, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'h77;
        step();
        n_checks++;
        if ({pc_d, pc_plus4_d, instr_d, imem_addr} !== {32'hFFFF_FFFC, 32'h0, 32'h77, 32'h0}) begin
            n_fail++; $display("FAIL wrap_next: got %h %h %h %h want fffffffc 0 77 0", pc_d, pc_plus4_d, instr_d, imem_addr);
        end
        imem_ack = 1'b0; redirect_e = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_e = 1'b0;
        n_checks++;
        if ({imem_req, imem_addr, fetch_busy} !== {1'b1, 32'h0, 1'b1}) begin
            n_fail++; $display("FAIL wrap_drop: got %b %h %b want 1 0 1", imem_req, imem_addr, fetch_busy);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, fetch_busy, if_valid, instr_d, pc_d, pc_plus4_d} !== {3'b000, 32'h13, 32'h0, 32'h0}) begin
            n_fail++; $display("FAIL async_reset: got %b%b%b %h %h %h want 000 13 0 0", imem_req, fetch_busy, if_valid, instr_d, pc_d, pc_plus4_d);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL post_reset_req: got %b %h want 1 0", imem_req, imem_addr);
        end
    endtask

    initial begin
        rst = 1'b0; stall_d = 1'b0; redirect_e = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_redirect_drop();
        test_stall_skid();
        test_redirect_hold();
        test_wrap_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
